ec_shamir_mul_ctrl: RTL and testbench

Sequencer that computes R = k1·P + k2·Q over the 16-bit prime-field curve (p = 65521, a = 2) by Shamir's trick: interleaved double-and-add driven MSB-first over both scalars. It owns no field arithmetic; every point operation is issued to the shared external point-add/double unit over a req/ack handshake. It tracks the point at infinity itself, because the adder cannot represent it. It sits between the ECDSA verify front end, which supplies u1, u2, G and Q, and the point-add datapath, replacing the linear repeated-add loops.

---
 rtl/ec_shamir_mul_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_ec_shamir_mul_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_shamir_mul_ctrl.sv
// Shamir's-trick sequencer for R = k1*P + k2*Q on a 16-bit prime-field curve.
// Field arithmetic lives in an external point-add/double unit; infinity is tracked here.
module ec_shamir_mul_ctrl #(
    parameter int KW = 7,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [KW-1:0] i_k1,
    input  logic [KW-1:0] i_k2,
    input  logic [CW-1:0] i_px,
    input  logic [CW-1:0] i_py,
    input  logic [CW-1:0] i_qx,
    input  logic [CW-1:0] i_qy,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_res_x,
    output logic [CW-1:0] o_res_y,
    output logic          o_res_inf,
    output logic          o_pa_req,
    output logic [CW-1:0] o_pa_x1,
    output logic [CW-1:0] o_pa_y1,
    output logic [CW-1:0] o_pa_x2,
    output logic [CW-1:0] o_pa_y2,
    input  logic          i_pa_ack,
    input  logic [CW-1:0] i_pa_x3,
    input  logic [CW-1:0] i_pa_y3
);
    localparam int IW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [IW-1:0] I_TOP = IW'(KW - 1);
    localparam logic [IW-1:0] I_ONE = IW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_DBL  = 3'd3;
    localparam logic [2:0] S_SEL  = 3'd4;
    localparam logic [2:0] S_ADD  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    logic [2:0]    r_state;
    logic [KW-1:0] r_k1, r_k2;
    logic [CW-1:0] r_px, r_py, r_qx, r_qy;
    logic [CW-1:0] r_pq_x, r_pq_y, r_acc_x, r_acc_y, r_op_x, r_op_y;
    logic          r_pq_inf, r_acc_inf, r_op_none;
    logic [IW-1:0] r_i;
    logic          r_busy, r_done, r_pa_req, r_res_inf;
    logic [CW-1:0] r_res_x, r_res_y;
    logic [CW-1:0] r_pa_x1, r_pa_y1, r_pa_x2, r_pa_y2;

    logic          w_pre_neg, w_add_neg, w_last;
    logic [1:0]    w_sel;
    logic [2:0]    w_adv_state;
    logic [IW-1:0] w_adv_i;

    // Same x with different y means the two points are inverses: the sum is infinity.
    assign w_pre_neg   = (r_px == r_qx) && (r_py != r_qy);
    assign w_add_neg   = (r_acc_x == r_op_x) && (r_acc_y != r_op_y);
    assign w_last      = (r_i == {IW{1'b0}});
    assign w_sel       = {r_k1[r_i], r_k2[r_i]};
    assign w_adv_state = w_last ? S_FIN : S_DBL;
    assign w_adv_i     = w_last ? r_i : (r_i - I_ONE);

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_res_x   = r_res_x;
    assign o_res_y   = r_res_y;
    assign o_res_inf = r_res_inf;
    assign o_pa_req  = r_pa_req;
    assign o_pa_x1   = r_pa_x1;
    assign o_pa_y1   = r_pa_y1;
    assign o_pa_x2   = r_pa_x2;
    assign o_pa_y2   = r_pa_y2;

    // Sequencer: in each op state the first cycle either resolves the op locally or raises pa_req.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_k1      <= {KW{1'b0}};
            r_k2      <= {KW{1'b0}};
            r_px      <= {CW{1'b0}};
            r_py      <= {CW{1'b0}};
            r_qx      <= {CW{1'b0}};
            r_qy      <= {CW{1'b0}};
            r_pq_x    <= {CW{1'b0}};
            r_pq_y    <= {CW{1'b0}};
            r_pq_inf  <= 1'b1;
            r_acc_x   <= {CW{1'b0}};
            r_acc_y   <= {CW{1'b0}};
            r_acc_inf <= 1'b1;
            r_op_x    <= {CW{1'b0}};
            r_op_y    <= {CW{1'b0}};
            r_op_none <= 1'b1;
            r_i       <= {IW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pa_req  <= 1'b0;
            r_res_x   <= {CW{1'b0}};
            r_res_y   <= {CW{1'b0}};
            r_res_inf <= 1'b1;
            r_pa_x1   <= {CW{1'b0}};
            r_pa_y1   <= {CW{1'b0}};
            r_pa_x2   <= {CW{1'b0}};
            r_pa_y2   <= {CW{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !r_done) begin
                        r_k1      <= i_k1;
                        r_k2      <= i_k2;
                        r_px      <= i_px;
                        r_py      <= i_py;
                        r_qx      <= i_qx;
                        r_qy      <= i_qy;
                        r_acc_inf <= 1'b1;
                        r_i       <= I_TOP;
                        r_busy    <= 1'b1;
                        r_state   <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (!r_pa_req) begin
                        if (w_pre_neg) begin
                            r_pq_inf <= 1'b1;
                            r_state  <= S_LOAD;
                        end else begin
                            r_pa_req <= 1'b1;
                            r_pa_x1  <= r_px;
                            r_pa_y1  <= r_py;
                            r_pa_x2  <= r_qx;
                            r_pa_y2  <= r_qy;
                        end
                    end else if (i_pa_ack) begin
                        r_pa_req <= 1'b0;
                        r_pq_x   <= i_pa_x3;
                        r_pq_y   <= i_pa_y3;
                        r_pq_inf <= 1'b0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: r_state <= S_DBL;
                S_DBL: begin
                    if (!r_pa_req) begin
                        if (r_acc_inf) begin
                            r_state <= S_SEL;
                        end else if (r_acc_y == {CW{1'b0}}) begin
                            r_acc_inf <= 1'b1;
                            r_state   <= S_SEL;
                        end else begin
                            r_pa_req <= 1'b1;
                            r_pa_x1  <= r_acc_x;
                            r_pa_y1  <= r_acc_y;
                            r_pa_x2  <= r_acc_x;
                            r_pa_y2  <= r_acc_y;
                        end
                    end else if (i_pa_ack) begin
                        r_pa_req <= 1'b0;
                        r_acc_x  <= i_pa_x3;
                        r_acc_y  <= i_pa_y3;
                        r_state  <= S_SEL;
                    end
                end
                S_SEL: begin
                    case (w_sel)
                        2'b10: begin
                            r_op_x    <= r_px;
                            r_op_y    <= r_py;
                            r_op_none <= 1'b0;
                        end
                        2'b01: begin
                            r_op_x    <= r_qx;
                            r_op_y    <= r_qy;
                            r_op_none <= 1'b0;
                        end
                        2'b11: begin
                            r_op_x    <= r_pq_x;
                            r_op_y    <= r_pq_y;
                            r_op_none <= r_pq_inf;
                        end
                        default: r_op_none <= 1'b1;
                    endcase
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    if (!r_pa_req) begin
                        if (r_op_none) begin
                            r_state <= w_adv_state;
                            r_i     <= w_adv_i;
                        end else if (r_acc_inf) begin
                            r_acc_x   <= r_op_x;
                            r_acc_y   <= r_op_y;
                            r_acc_inf <= 1'b0;
                            r_state   <= w_adv_state;
                            r_i       <= w_adv_i;
                        end else if (w_add_neg) begin
                            r_acc_inf <= 1'b1;
                            r_state   <= w_adv_state;
                            r_i       <= w_adv_i;
                        end else begin
                            r_pa_req <= 1'b1;
                            r_pa_x1  <= r_acc_x;
                            r_pa_y1  <= r_acc_y;
                            r_pa_x2  <= r_op_x;
                            r_pa_y2  <= r_op_y;
                        end
                    end else if (i_pa_ack) begin
                        r_pa_req <= 1'b0;
                        r_acc_x  <= i_pa_x3;
                        r_acc_y  <= i_pa_y3;
                        r_state  <= w_adv_state;
                        r_i      <= w_adv_i;
                    end
                end
                S_FIN: begin
                    r_res_x   <= r_acc_x;
                    r_res_y   <= r_acc_y;
                    r_res_inf <= r_acc_inf;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_pa_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ec_shamir_mul_ctrl.sv
// Bench for ec_shamir_mul_ctrl: a behavioural point-adder answers the handshake, and results
// are compared with an LSB-first double-and-add reference over p = 65521, a = 2.
module tb_ec_shamir_mul_ctrl;
    typedef struct packed {
        logic        inf;
        logic [15:0] x;
        logic [15:0] y;
    } pt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  k1 = 7'd0, k2 = 7'd0;
    logic [15:0] px = 16'd0, py = 16'd0, qx = 16'd0, qy = 16'd0;
    logic        busy, done, res_inf, pa_req;
    logic [15:0] res_x, res_y, pa_x1, pa_y1, pa_x2, pa_y2;
    logic        pa_ack = 1'b0;
    logic [15:0] pa_x3 = 16'd0, pa_y3 = 16'd0;

    int tests = 0;
    int fails = 0;

    int req_count = 0;
    int stable_err = 0;
    int drop_err = 0;
    int max_delay = 0;
    bit hold_acks = 1'b0;
    bit inject_ack = 1'b0;

    pt_t gp, gq, gneg;

    ec_shamir_mul_ctrl #(.KW(7), .CW(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_k1(k1), .i_k2(k2), .i_px(px), .i_py(py), .i_qx(qx), .i_qy(qy),
        .o_busy(busy), .o_done(done), .o_res_x(res_x), .o_res_y(res_y), .o_res_inf(res_inf),
        .o_pa_req(pa_req), .o_pa_x1(pa_x1), .o_pa_y1(pa_y1), .o_pa_x2(pa_x2), .o_pa_y2(pa_y2),
        .i_pa_ack(pa_ack), .i_pa_x3(pa_x3), .i_pa_y3(pa_y3)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] t;
        t = 32'(a) * 32'(b);
        return 16'(t % 32'd65521);
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = 17'(a) + 17'(b);
        if (s >= 17'd65521) s = s - 17'd65521;
        return s[15:0];
    endfunction

    function automatic logic [15:0] fsub(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = (a >= b) ? 17'(a - b) : (17'(a) + 17'd65521 - 17'(b));
        return s[15:0];
    endfunction

    function automatic logic [15:0] finv(input logic [15:0] a);
        logic [15:0] r, b, e;
        r = 16'd1; b = a; e = 16'd65519;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = fmul(r, b);
            b = fmul(b, b);
        end
        return r;
    endfunction

    function automatic pt_t pdbl(input pt_t a);
        pt_t r;
        logic [15:0] l;
        if (a.inf || a.y == 16'd0) begin
            r = '{inf: 1'b1, x: 16'd0, y: 16'd0};
        end else begin
            l = fmul(fadd(fmul(16'd3, fmul(a.x, a.x)), 16'd2), finv(fadd(a.y, a.y)));
            r.inf = 1'b0;
            r.x = fsub(fmul(l, l), fadd(a.x, a.x));
            r.y = fsub(fmul(l, fsub(a.x, r.x)), a.y);
        end
        return r;
    endfunction

    function automatic pt_t padd(input pt_t a, input pt_t b);
        pt_t r;
        logic [15:0] l;
        if (a.inf) r = b;
        else if (b.inf) r = a;
        else if (a.x == b.x && a.y == b.y) r = pdbl(a);
        else if (a.x == b.x) r = '{inf: 1'b1, x: 16'd0, y: 16'd0};
        else begin
            l = fmul(fsub(b.y, a.y), finv(fsub(b.x, a.x)));
            r.inf = 1'b0;
            r.x = fsub(fsub(fmul(l, l), a.x), b.x);
            r.y = fsub(fmul(l, fsub(a.x, r.x)), a.y);
        end
        return r;
    endfunction

    function automatic pt_t pmul(input logic [6:0] k, input pt_t p);
        pt_t r, b;
        r = '{inf: 1'b1, x: 16'd0, y: 16'd0};
        b = p;
        for (int i = 0; i < 7; i++) begin
            if (k[i]) r = padd(r, b);
            b = padd(b, b);
        end
        return r;
    endfunction

    // Behavioural point-add unit: random ack delay, operand-stability and early-drop tracking.
    initial begin : adder_model
        bit pending;
        int wait_cnt;
        logic [15:0] sx1, sy1, sx2, sy2;
        pt_t t;
        pending = 1'b0; wait_cnt = 0;
        sx1 = 16'd0; sy1 = 16'd0; sx2 = 16'd0; sy2 = 16'd0;
        forever begin
            @(negedge clk);
            pa_ack = 1'b0;
            if (inject_ack) begin
                pa_ack = 1'b1;
                pa_x3 = 16'h1234;
                pa_y3 = 16'h5678;
                pending = 1'b0;
            end else if (pa_req === 1'b1) begin
                if (!pending) begin
                    pending = 1'b1;
                    req_count++;
                    sx1 = pa_x1; sy1 = pa_y1; sx2 = pa_x2; sy2 = pa_y2;
                    wait_cnt = $urandom_range(max_delay, 0);
                end else if ({pa_x1, pa_y1, pa_x2, pa_y2} !== {sx1, sy1, sx2, sy2}) begin
                    stable_err++;
                end
                if (!hold_acks && wait_cnt == 0) begin
                    t = padd('{inf: 1'b0, x: sx1, y: sy1}, '{inf: 1'b0, x: sx2, y: sy2});
                    pa_x3 = t.x;
                    pa_y3 = t.y;
                    pa_ack = 1'b1;
                    pending = 1'b0;
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end
            end else begin
                if (pending && !hold_acks) drop_err++;
                pending = 1'b0;
            end
        end
    end

    task automatic run_mul(input logic [6:0] k1v, input logic [6:0] k2v, input pt_t p, input pt_t q,
                           input int maxd, input bit poke, input bit start_at_done,
                           output pt_t res, output int nreq);
        int base;
        bit got;
        @(negedge clk);
        k1 = k1v; k2 = k2v; px = p.x; py = p.y; qx = q.x; qy = q.y;
        max_delay = maxd;
        base = req_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: busy=%b want 1", busy);
        end
        got = 1'b0;
        for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (poke && cyc == 12) begin
                    start = 1'b1; k1 = ~k1v; k2 = ~k2v;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL done_timeout: no done within 5000 cycles, want done");
            res = '{inf: 1'b0, x: 16'd0, y: 16'd0};
            nreq = -1;
            return;
        end
        res = {res_inf, res_x, res_y};
        nreq = req_count - base;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_at_done: busy=%b want 0", busy);
        end
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset;
        tests++;
        if ({busy, done, pa_req, res_inf} !== 4'b0001 || {res_x, res_y} !== 32'd0 ||
            {pa_x1, pa_y1, pa_x2, pa_y2} !== 64'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b req=%b inf=%b res=%h,%h ops=%h%h%h%h want 0 0 0 1 zeros",
                     busy, done, pa_req, res_inf, res_x, res_y, pa_x1, pa_y1, pa_x2, pa_y2);
        end
    endtask

    task automatic test_zero_scalars;
        pt_t r; int n;
        run_mul(7'd0, 7'd0, gp, gq, 0, 1'b0, 1'b0, r, n);
        tests++;
        if (r.inf !== 1'b1 || n !== 1) begin
            fails++;
            $display("FAIL zero_scalars: inf=%b reqs=%0d want inf=1 reqs=1", r.inf, n);
        end
    endtask

    task automatic test_single_bits;
        pt_t r, e; int n;
        run_mul(7'd1, 7'd0, gp, gq, 0, 1'b0, 1'b0, r, n);
        tests++;
        if (r !== gp || n !== 1) begin
            fails++;
            $display("FAIL k1_one: got %b,%h,%h reqs=%0d want %b,%h,%h reqs=1", r.inf, r.x, r.y, n, gp.inf, gp.x, gp.y);
        end
        e = pdbl(gp);
        run_mul(7'd2, 7'd0, gp, gq, 0, 1'b0, 1'b0, r, n);
        tests++;
        if (r !== e || n !== 2) begin
            fails++;
            $display("FAIL k1_two: got %b,%h,%h reqs=%0d want %b,%h,%h reqs=2", r.inf, r.x, r.y, n, e.inf, e.x, e.y);
        end
    endtask

    task automatic test_pq_inf;
        pt_t r; int n;
        run_mul(7'd5, 7'd5, gp, gneg, 0, 1'b0, 1'b0, r, n);
        tests++;
        if (r.inf !== 1'b1 || n !== 0) begin
            fails++;
            $display("FAIL pq_inf: inf=%b reqs=%0d want inf=1 reqs=0", r.inf, n);
        end
    endtask

    task automatic test_shamir_delay;
        pt_t r, e; int n;
        e = padd(pmul(7'h53, gp), pmul(7'h2a, gq));
        run_mul(7'h53, 7'h2a, gp, gq, 5, 1'b1, 1'b0, r, n);
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL shamir_53_2a: got %b,%h,%h want %b,%h,%h", r.inf, r.x, r.y, e.inf, e.x, e.y);
        end
        tests++;
        if (n < 1 || n > 15) begin
            fails++;
            $display("FAIL shamir_op_count: reqs=%0d want 1..15", n);
        end
    endtask

    task automatic test_random;
        pt_t r, e, q; int n;
        logic [6:0] a, b;
        for (int it = 0; it < 6; it++) begin
            a = 7'($urandom_range(127, 0));
            b = 7'($urandom_range(127, 0));
            q = pmul(7'($urandom_range(9, 2)), gp);
            e = padd(pmul(a, gp), pmul(b, q));
            run_mul(a, b, gp, q, $urandom_range(3, 0), 1'b0, 1'b0, r, n);
            tests++;
            if ((e.inf ? (r.inf !== 1'b1) : (r !== e)) || n > 15) begin
                fails++;
                $display("FAIL random_%0d k1=%h k2=%h: got %b,%h,%h reqs=%0d want %b,%h,%h reqs<=15",
                         it, a, b, r.inf, r.x, r.y, n, e.inf, e.x, e.y);
            end
        end
    endtask

    task automatic test_back_to_back;
        pt_t r, e; int n;
        e = padd(pmul(7'd3, gp), pmul(7'd6, gq));
        run_mul(7'd3, 7'd6, gp, gq, 1, 1'b0, 1'b1, r, n);
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL b2b_first: got %b,%h,%h want %b,%h,%h", r.inf, r.x, r.y, e.inf, e.x, e.y);
        end
        run_mul(7'd1, 7'd0, gp, gq, 0, 1'b0, 1'b0, r, n);
        tests++;
        if (r !== gp) begin
            fails++;
            $display("FAIL b2b_second: got %b,%h,%h want %b,%h,%h", r.inf, r.x, r.y, gp.inf, gp.x, gp.y);
        end
    endtask

    task automatic test_reset_midop;
        pt_t r, e; int n;
        bit seen;
        hold_acks = 1'b1;
        @(negedge clk);
        k1 = 7'h7f; k2 = 7'h55; px = gp.x; py = gp.y; qx = gq.x; qy = gq.y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (pa_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL midop_req: pa_req=%b want 1 within 20 cycles", pa_req);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({pa_req, busy, res_inf, done} !== 4'b0010) begin
            fails++;
            $display("FAIL midop_reset: req=%b busy=%b inf=%b done=%b want 0 0 1 0", pa_req, busy, res_inf, done);
        end
        inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        hold_acks = 1'b0;
        @(negedge clk);
        tests++;
        if ({pa_req, busy, res_inf} !== 3'b001) begin
            fails++;
            $display("FAIL late_ack_ignored: req=%b busy=%b inf=%b want 0 0 1", pa_req, busy, res_inf);
        end
        e = padd(pmul(7'h11, gp), pmul(7'h22, gq));
        run_mul(7'h11, 7'h22, gp, gq, 2, 1'b0, 1'b0, r, n);
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL after_reset_run: got %b,%h,%h want %b,%h,%h", r.inf, r.x, r.y, e.inf, e.x, e.y);
        end
    endtask

    task automatic test_handshake_rules;
        tests++;
        if (stable_err !== 0 || drop_err !== 0) begin
            fails++;
            $display("FAIL handshake: operand_changes=%0d early_drops=%0d want 0 0", stable_err, drop_err);
        end
    endtask

    initial begin
        gp = '{inf: 1'b0, x: 16'd3, y: 16'hffeb};
        gq = pdbl(gp);
        gneg = '{inf: 1'b0, x: gp.x, y: fsub(16'd0, gp.y)};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero_scalars();
        test_single_bits();
        test_pq_inf();
        test_shamir_delay();
        test_random();
        test_back_to_back();
        test_reset_midop();
        test_handshake_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
